// File: rtl/exp_table_loader.sv
// Streams 2*N_PER_SGN exp coefficients into the exp MAC stage table.
// Entries go sgn0 idx0..N-1, then sgn1 idx0..N-1; abort cancels a load.
module exp_table_loader #(
  parameter int N_PER_SGN = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        cfg_w_en,
  output logic        cfg_sgn,
  output logic [3:0]  cfg_idx,
  output logic [15:0] cfg_base,
  output logic [15:0] cfg_offset,
  output logic        busy,
  output logic        done,
  output logic        loaded
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_PER_SGN - 1);

  state_t     state;
  state_t     state_nx;
  logic       sgn_q;
  logic [3:0] idx_q;
  logic       accept;
  logic       last_beat;
  logic       load_go;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) state_nx = LOAD;
      end
      LOAD: begin
        if (abort || last_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state == LOAD) && !abort;
    busy      = (state == LOAD);
    accept    = s_valid && s_ready;
    last_beat = accept && sgn_q && (idx_q == LAST_IDX);
    load_go   = (state == IDLE) && start && !abort;
  end

  // Entry counters: idx wraps into the sgn1 half after the last sgn0 bucket.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_q <= 1'b0;
      idx_q <= 4'd0;
    end else if (load_go) begin
      sgn_q <= 1'b0;
      idx_q <= 4'd0;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        idx_q <= 4'd0;
        sgn_q <= 1'b1;
      end else begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_w_en   <= 1'b0;
      cfg_sgn    <= 1'b0;
      cfg_idx    <= 4'd0;
      cfg_base   <= 16'd0;
      cfg_offset <= 16'd0;
    end else begin
      cfg_w_en <= accept;
      if (accept) begin
        cfg_sgn    <= sgn_q;
        cfg_idx    <= idx_q;
        cfg_base   <= s_data[31:16];
        cfg_offset <= s_data[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done   <= 1'b0;
      loaded <= 1'b0;
    end else begin
      done <= last_beat;
      if (load_go) begin
        loaded <= 1'b0;
      end else if (last_beat) begin
        loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exp_table_loader.sv
// Bench for exp_table_loader: directed vector table, scenario
// sequences and random traffic checked against an entry-count model.
module tb_exp_table_loader;

  localparam int N = 13;
  localparam int TOTAL = 2 * N;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        cfg_w_en;
  logic        cfg_sgn;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_base;
  logic [15:0] cfg_offset;
  logic        busy;
  logic        done;
  logic        loaded;

  exp_table_loader #(.N_PER_SGN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .cfg_w_en  (cfg_w_en),
    .cfg_sgn   (cfg_sgn),
    .cfg_idx   (cfg_idx),
    .cfg_base  (cfg_base),
    .cfg_offset(cfg_offset),
    .busy      (busy),
    .done      (done),
    .loaded    (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a load is a count k of accepted entries out of 2N.
  bit          m_load;
  int          m_k;
  bit          m_loaded;
  bit          m_done;
  bit          m_wen;
  int          m_sgn;
  int          m_idx;
  logic [15:0] m_base;
  logic [15:0] m_off;
  int          dut_wr;
  int          dut_done;

  typedef struct {
    logic        st;
    logic        ab;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        wen;
    logic        sgn;
    logic [3:0]  idx;
    logic [15:0] base;
    logic        bsy;
    logic        dn;
    logic        ld;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(
    input logic st, ab, v, input logic [31:0] d,
    input logic rdy, wen, sgn, input logic [3:0] idx,
    input logic [15:0] base, input logic bsy, dn, ld);
    vec_t r;
    r.st = st; r.ab = ab; r.v = v; r.d = d;
    r.rdy = rdy; r.wen = wen; r.sgn = sgn; r.idx = idx;
    r.base = base; r.bsy = bsy; r.dn = dn; r.ld = ld;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_k = 0; m_loaded = 0; m_done = 0; m_wen = 0;
    m_sgn = 0; m_idx = 0; m_base = '0; m_off = '0;
  endtask

  // Called at posedge+1: drive, check comb outputs, clock, check registers.
  task automatic step(input logic st, input logic ab, input logic v,
                      input logic [31:0] d);
    bit rdy;
    bit acc;
    start = st; abort = ab; s_valid = v; s_data = d;
    #1;
    rdy = m_load && !ab;
    check("s_ready", {31'd0, s_ready}, {31'd0, rdy});
    check("busy_pre", {31'd0, busy}, {31'd0, m_load});
    acc = rdy && v;
    m_wen = acc;
    m_done = 0;
    if (acc) begin
      m_sgn = m_k / N;
      m_idx = m_k % N;
      m_base = d[31:16];
      m_off = d[15:0];
      m_k++;
      if (m_k == TOTAL) begin
        m_load = 0; m_done = 1; m_loaded = 1;
      end
    end else if (m_load && ab) begin
      m_load = 0;
    end else if (!m_load && st && !ab) begin
      m_load = 1; m_k = 0; m_loaded = 0;
    end
    @(posedge clk);
    #1;
    if (cfg_w_en) dut_wr++;
    if (done) dut_done++;
    check("cfg_w_en", {31'd0, cfg_w_en}, {31'd0, m_wen});
    check("cfg_sgn", {31'd0, cfg_sgn}, m_sgn);
    check("cfg_idx", {28'd0, cfg_idx}, m_idx);
    check("cfg_base", {16'd0, cfg_base}, {16'd0, m_base});
    check("cfg_offset", {16'd0, cfg_offset}, {16'd0, m_off});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("loaded", {31'd0, loaded}, {31'd0, m_loaded});
    check("busy", {31'd0, busy}, {31'd0, m_load});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, $urandom);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the edge.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_w_en", {31'd0, cfg_w_en}, 0);
    check("rst_sgn", {31'd0, cfg_sgn}, 0);
    check("rst_idx", {28'd0, cfg_idx}, 0);
    check("rst_base", {16'd0, cfg_base}, 0);
    check("rst_offset", {16'd0, cfg_offset}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_loaded", {31'd0, loaded}, 0);
    start = 0; abort = 0; s_valid = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic beat(input logic st, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    step(st, 0, 1, {kk + 16'h3F00, kk});
  endtask

  initial begin
    rst = 1'b0; start = 0; abort = 0; s_valid = 0; s_data = '0;
    model_reset();
    dut_wr = 0; dut_done = 0;

    tbl[0] = mk(1, 1, 0, 32'h0,         0, 0, 0, 0, 16'h0,    0, 0, 0);
    tbl[1] = mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 16'h0,    1, 0, 0);
    tbl[2] = mk(1, 0, 1, 32'h3F00_0000, 1, 1, 0, 0, 16'h3F00, 1, 0, 0);
    tbl[3] = mk(0, 0, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 16'h3F00, 1, 0, 0);
    tbl[4] = mk(0, 0, 1, 32'h3F01_0001, 1, 1, 0, 1, 16'h3F01, 1, 0, 0);
    tbl[5] = mk(1, 0, 1, 32'h3F02_0002, 1, 1, 0, 2, 16'h3F02, 1, 0, 0);
    tbl[6] = mk(0, 1, 1, 32'h1234_5678, 0, 0, 0, 2, 16'h3F02, 0, 0, 0);
    tbl[7] = mk(0, 0, 1, 32'h1111_2222, 0, 0, 0, 2, 16'h3F02, 0, 0, 0);
    tbl[8] = mk(1, 0, 0, 32'h0,         0, 0, 0, 2, 16'h3F02, 1, 0, 0);
    tbl[9] = mk(0, 0, 1, 32'hAAAA_5555, 1, 1, 0, 0, 16'hAAAA, 1, 0, 0);

    #2;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_loaded", {31'd0, loaded}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; abort = tbl[i].ab;
      s_valid = tbl[i].v; s_data = tbl[i].d;
      #1;
      check($sformatf("t%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].rdy});
      @(posedge clk);
      #1;
      check($sformatf("t%0d_wen", i), {31'd0, cfg_w_en}, {31'd0, tbl[i].wen});
      check($sformatf("t%0d_sgn", i), {31'd0, cfg_sgn}, {31'd0, tbl[i].sgn});
      check($sformatf("t%0d_idx", i), {28'd0, cfg_idx}, {28'd0, tbl[i].idx});
      check($sformatf("t%0d_base", i), {16'd0, cfg_base}, {16'd0, tbl[i].base});
      check($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      check($sformatf("t%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
      check($sformatf("t%0d_loaded", i), {31'd0, loaded}, {31'd0, tbl[i].ld});
    end

    // Table leaves a load in flight with a write on the outputs.
    async_reset();
    idle(2);

    // Back-to-back load.
    dut_wr = 0; dut_done = 0;
    step(1, 0, 0, 0);
    for (int k = 0; k < TOTAL; k++) beat(0, k);
    idle(2);
    check("b2b_writes", dut_wr, TOTAL);
    check("b2b_done", dut_done, 1);
    check("b2b_loaded", {31'd0, loaded}, 1);

    // Start+abort in IDLE must leave loaded intact.
    step(1, 1, 1, 32'h5555_AAAA);
    step(0, 1, 0, 0);
    check("idle_abort_loaded", {31'd0, loaded}, 1);

    // Stalled load with 3-cycle gaps.
    dut_wr = 0; dut_done = 0;
    step(1, 0, 0, 0);
    check("reload_clears_loaded", {31'd0, loaded}, 0);
    for (int k = 0; k < TOTAL; k++) begin
      beat(0, k);
      idle(3);
    end
    check("stall_writes", dut_wr, TOTAL);
    check("stall_done", dut_done, 1);

    // Abort after 5 beats with s_valid still high.
    dut_wr = 0; dut_done = 0;
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) beat(0, k);
    step(0, 1, 1, 32'h7777_7777);
    idle(3);
    check("abort_writes", dut_wr, 5);
    check("abort_done", dut_done, 0);
    check("abort_loaded", {31'd0, loaded}, 0);
    step(1, 0, 0, 0);
    beat(0, 40);
    check("post_abort_idx", {28'd0, cfg_idx}, 0);
    step(0, 1, 0, 0);

    // Reset mid-load, then a clean full load with start held high.
    step(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) beat(0, k);
    async_reset();
    dut_wr = 0; dut_done = 0;
    step(1, 0, 0, 0);
    for (int k = 0; k < TOTAL; k++) begin
      beat(1, k + 100);
      if (k % 4 == 1) step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    check("held_start_writes", dut_wr, TOTAL);
    check("held_start_done", dut_done, 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_table_loader.md
EXP_TABLE_LOADER -- requirements
Module: exp_table_loader

Interface
REQ-001 The block SHALL have parameter N_PER_SGN, default 13, meaning table entries per sign half (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a full table load.
REQ-005 The block SHALL have port abort, input, 1, a request to cancel an in-progress load.
REQ-006 The block SHALL have port s_valid, input, 1, coefficient beat valid.
REQ-007 The block SHALL have port s_ready, output, 1, coefficient beat ready.
REQ-008 The block SHALL have port s_data, input, 32, the coefficient beat: [31:16] base, [15:0] offset.
REQ-009 The block SHALL have port cfg_w_en, output, 1, table write strobe to the exp MAC stage.
REQ-010 The block SHALL have port cfg_sgn, output, 1, sign half being written.
REQ-011 The block SHALL have port cfg_idx, output, 4, exponent bucket being written.
REQ-012 The block SHALL have ports cfg_base and cfg_offset, output, 16 each, the entry payload.
REQ-013 The block SHALL have port busy, output, 1, high while a load is in progress.
REQ-014 The block SHALL have port done, output, 1, one-cycle pulse on load completion.
REQ-015 The block SHALL have port loaded, output, 1, level indicating a complete table is resident.

Function
REQ-016 FSM states SHALL be IDLE and LOAD; busy = (state == LOAD).
REQ-017 IDLE with start=1 and abort=0 SHALL go to LOAD, clear the sgn/idx counters to 0/0, and clear loaded.
REQ-018 start SHALL be ignored in LOAD.
REQ-019 s_ready SHALL be combinational: (state == LOAD) and not abort.
REQ-020 A beat SHALL be accepted only in a cycle where s_valid and s_ready are both 1; s_data is don't-care otherwise.
REQ-021 On acceptance, the next cycle SHALL present cfg_w_en=1, cfg_sgn/cfg_idx equal to the pre-increment counters, cfg_base=s_data[31:16], and cfg_offset=s_data[15:0], all from registers.
REQ-022 cfg_w_en SHALL be 0 in every cycle not directly following an acceptance; cfg_sgn, cfg_idx, cfg_base and cfg_offset hold their last values.
REQ-023 Entry order SHALL be sgn 0 idx 0..N_PER_SGN-1, then sgn 1 idx 0..N_PER_SGN-1; idx wraps to 0 and sgn sets to 1 after idx N_PER_SGN-1 of sgn 0.
REQ-024 Acceptance of entry 2*N_PER_SGN-1 SHALL return the FSM to IDLE next cycle; in that same cycle done=1 for exactly one cycle, loaded=1, and the final cfg_w_en is asserted.
REQ-025 abort=1 in LOAD SHALL force s_ready=0 in that cycle and return to IDLE next cycle; loaded stays 0 and done is not pulsed.
REQ-026 After an abort, a write already launched by an acceptance in the previous cycle SHALL still complete.
REQ-027 abort in IDLE, including together with start, SHALL have no effect: the FSM stays IDLE and loaded is unchanged.
REQ-028 Gaps in s_valid SHALL stall the load indefinitely with no timeout and no spurious writes.
REQ-029 A new start after completion SHALL reload from entry 0 and clear loaded until the new load completes.

Reset
REQ-030 While rst=0, all registers SHALL clear immediately: state=IDLE, counters=0, and cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset, done, loaded all 0; s_ready=0 and busy=0.
REQ-031 Reset mid-load SHALL abandon the load without completing a pending write; loaded=0 after release.

Verification
REQ-032 Reset check: assert rst=0 asynchronously mid-cycle -> all outputs read 0 before the next clk edge.
REQ-033 Back-to-back load: start, then 26 beats with s_data={k+16'h3F00, k}, s_valid held 1 -> 26 cfg_w_en pulses in consecutive cycles with sgn/idx 0/0..0/12 then 1/0..1/12, cfg_base=16'h3F00+k; done pulses with the 26th write; loaded=1 and busy=0 afterwards.
REQ-034 Stall: insert 3-cycle s_valid gaps between beats -> writes only after acceptances, total still 26, same order.
REQ-035 Abort: abort with s_valid=1 after 5 accepted beats -> exactly 5 writes, s_ready=0 in the abort cycle, no done, loaded=0; a subsequent start writes sgn0/idx0 first.
REQ-036 Reset mid-load: rst=0 after 10 beats -> outputs 0 and IDLE; a fresh start then completes normally.
REQ-037 start held high during LOAD and start+abort in IDLE -> no counter reset, no state change; entry sequence unaffected.
